memory_access: RTL and testbench

//  Memory stage of the 5-stage RV64 pipeline: consumer of execute_data_t. Issues loads/stores on dbus.

---
 rtl/memory_access_pkg.sv | 94 +++++++++
 rtl/memory_access_align.sv | 53 +++++
 rtl/memory_access.sv | 147 ++++++++++++++
 tb/tb_memory_access.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_access_pkg.sv
// memory_access_pkg
//   Shared types for the memory stage of the RV64 pipeline: scalar typedefs,
//   access size encoding, control word, stage payloads and data-bus request/
//   response records. It also holds the small helpers used by the stage and
//   by its alignment unit.
//   The optional misalignment trap is enabled with the macro MEM_MISALIGN_CHECK_EN
//   (see memory_access.sv). The helpers below are shared by both builds.
package memory_access_pkg;

    localparam int XLEN      = 64;
    localparam int BUS_BYTES = 8;
    localparam int OFF_W     = $clog2(BUS_BYTES);
    localparam int SH_W      = OFF_W + 3;

    typedef logic [XLEN-1:0]      u64;
    typedef logic [BUS_BYTES-1:0] u8;

    // Encoded as log2(bytes).
    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef struct packed {
        logic   MemRead;
        logic   MemWrite;
        logic   MemUnsigned;
        msize_t msize;
        logic   RegWrite;
        logic   exc_misalign;
    } ctl_t;

    typedef struct packed {
        u64   pc;
        ctl_t ctl;
        u64   rs2;
        u64   alu;
    } execute_data_t;

    typedef struct packed {
        u64   pc;
        ctl_t ctl;
        u64   result;
    } memory_data_t;

    typedef struct packed {
        logic   valid;
        u64     addr;
        msize_t size;
        u8      strobe;
        u64     data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    // Byte-lane mask of an access that starts at lane 0.
    function automatic u8 size_mask(msize_t size);
        u8 m;
        case (size)
            MSIZE1:  m = 8'h01;
            MSIZE2:  m = 8'h03;
            MSIZE4:  m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // An access is misaligned when its lane offset is not a multiple of its size.
    function automatic logic is_misaligned(logic [OFF_W-1:0] off, msize_t size);
        logic m;
        case (size)
            MSIZE2:  m = off[0];
            MSIZE4:  m = |off[1:0];
            MSIZE8:  m = |off;
            default: m = 1'b0;
        endcase
        return m;
    endfunction

    // Forward a control word with the misalignment flag replaced.
    function automatic ctl_t pass_ctl(ctl_t c, logic exc);
        ctl_t r;
        r              = c;
        r.exc_misalign = exc;
        return r;
    endfunction

endpackage

// File: rtl/memory_access_align.sv
// mem_align
//   Combinational byte-lane steering for the memory stage.
//   Store side: builds the write strobe and shifts the store data into its
//   lanes. Load side: shifts the returned bus word down to lane 0, truncates
//   it to the access size and sign- or zero-extends it.
//   Ports:
//     off          in   lane offset (low address bits)
//     size         in   access size
//     is_store     in   access is a store (strobe/data are zero otherwise)
//     is_unsigned  in   zero-extend loads instead of sign-extending
//     store_data   in   register value to be stored (lane 0 aligned)
//     load_data    in   raw bus read data
//     strobe       out  byte write enables
//     wdata        out  lane-aligned store data
//     load_result  out  extracted and extended load value
//   Lanes shifted past the top of the bus are dropped, never wrapped.
module mem_align
    import memory_access_pkg::*;
(
    input  logic [OFF_W-1:0] off,
    input  msize_t           size,
    input  logic             is_store,
    input  logic             is_unsigned,
    input  u64               store_data,
    input  u64               load_data,
    output u8                strobe,
    output u64               wdata,
    output u64               load_result
);

    logic [SH_W-1:0] shamt;
    u64              raw;

    assign shamt = {off, 3'b000};
    assign raw   = load_data >> shamt;

    assign strobe = is_store ? u8'(size_mask(size) << off) : '0;
    assign wdata  = is_store ? (store_data << shamt) : '0;

    always_comb begin
        load_result = raw;
        case (size)
            MSIZE1:  load_result = is_unsigned ? {56'd0, raw[7:0]}
                                               : {{56{raw[7]}}, raw[7:0]};
            MSIZE2:  load_result = is_unsigned ? {48'd0, raw[15:0]}
                                               : {{48{raw[15]}}, raw[15:0]};
            MSIZE4:  load_result = is_unsigned ? {32'd0, raw[31:0]}
                                               : {{32{raw[31]}}, raw[31:0]};
            default: load_result = raw;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// memory_access
//   Memory stage of the 5-stage RV64 pipeline. Accepts execute_data_t from
//   execute, issues loads/stores on the data bus, and hands memory_data_t to
//   writeback. Execute is back-pressured while a bus access is outstanding or
//   while writeback stalls the held result.
//   Ports:
//     clk     in   pipeline clock, all state on posedge
//     resetn  in   asynchronous active-low reset
//     dataE   in   pc, ctl, rs2 (store data), alu (address or result)
//     validE  in   dataE valid
//     readyM  out  stage accepts dataE this cycle
//     dataM   out  pc, ctl, result (alu or load data)
//     validM  out  dataM valid
//     readyW  in   writeback accepts dataM
//     dreq    out  data-bus request (valid, addr, size, strobe, data)
//     dresp   in   data-bus response (addr_ok, data_ok, data)
//   Build option: MEM_MISALIGN_CHECK_EN
//     defined   - misaligned memory ops make no bus request; they go straight
//                 to writeback with ctl.exc_misalign=1 and result=address.
//     undefined - exc_misalign is always 0 and misaligned ops are issued as-is.
//
//   state  | meaning
//   IDLE   | nothing held, ready for execute
//   BUS    | bus request driven, waiting for data_ok
//   HOLD   | dataM valid, waiting for writeback
module memory_access
    import memory_access_pkg::*;
(
    input  logic          clk,
    input  logic          resetn,
    input  execute_data_t dataE,
    input  logic          validE,
    output logic          readyM,
    output memory_data_t  dataM,
    output logic          validM,
    input  logic          readyW,
    output dbus_req_t     dreq,
    input  dbus_resp_t    dresp
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_d;
    execute_data_t req_q;
    execute_data_t req_d;
    memory_data_t  data_d;

    logic accept;
    logic is_mem_e;
    logic misalign_e;

    u8    strobe;
    u64   wdata;
    u64   load_result;

    // Address handshake is not needed: the request is held until data_ok.
    logic unused_resp;
    assign unused_resp = dresp.addr_ok;

    // In HOLD the next op is taken in the same cycle writeback drains us.
    assign readyM   = (state == S_IDLE) || ((state == S_HOLD) && readyW);
    assign validM   = (state == S_HOLD);
    assign accept   = validE && readyM;
    assign is_mem_e = dataE.ctl.MemRead | dataE.ctl.MemWrite;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign_e = is_mem_e && is_misaligned(dataE.alu[OFF_W-1:0], dataE.ctl.msize);
`else
    assign misalign_e = 1'b0;
`endif

    mem_align u_align (
        .off         (req_q.alu[OFF_W-1:0]),
        .size        (req_q.ctl.msize),
        .is_store    (req_q.ctl.MemWrite),
        .is_unsigned (req_q.ctl.MemUnsigned),
        .store_data  (req_q.rs2),
        .load_data   (dresp.data),
        .strobe      (strobe),
        .wdata       (wdata),
        .load_result (load_result)
    );

    // Request fields come straight from the latched op, so they cannot move
    // while the bus is waiting.
    always_comb begin
        dreq        = '0;
        dreq.valid  = (state == S_BUS);
        dreq.addr   = req_q.alu;
        dreq.size   = req_q.ctl.msize;
        dreq.strobe = strobe;
        dreq.data   = wdata;
    end

    always_comb begin
        state_d = state;
        req_d   = req_q;
        data_d  = dataM;

        case (state)
            S_IDLE: ;
            S_BUS: begin
                if (dresp.data_ok) begin
                    data_d.pc     = req_q.pc;
                    data_d.ctl    = pass_ctl(req_q.ctl, 1'b0);
                    data_d.result = req_q.ctl.MemRead ? load_result : req_q.alu;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (readyW) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Same accept rules from IDLE and from a draining HOLD.
        if (accept) begin
            if (is_mem_e && !misalign_e) begin
                req_d   = dataE;
                state_d = S_BUS;
            end else begin
                data_d.pc     = dataE.pc;
                data_d.ctl    = pass_ctl(dataE.ctl, misalign_e);
                data_d.result = dataE.alu;
                state_d       = S_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            req_q <= '0;
            dataM <= '0;
        end else begin
            state <= state_d;
            req_q <= req_d;
            dataM <= data_d;
        end
    end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    import memory_access_pkg::*;

    logic          clk;
    logic          resetn;
    execute_data_t dataE;
    logic          validE;
    logic          readyM;
    memory_data_t  dataM;
    logic          validM;
    logic          readyW;
    dbus_req_t     dreq;
    dbus_resp_t    dresp;

    memory_access dut (
        .clk    (clk),
        .resetn (resetn),
        .dataE  (dataE),
        .validE (validE),
        .readyM (readyM),
        .dataM  (dataM),
        .validM (validM),
        .readyW (readyW),
        .dreq   (dreq),
        .dresp  (dresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        execute_data_t e;
        u64            rdata;
        int unsigned   delay;
    } op_t;

    typedef struct {
        u64   pc;
        ctl_t ctl;
        u64   result;
        bit   chk_result;
    } exp_t;

`ifdef MEM_MISALIGN_CHECK_EN
    localparam bit MISAL_EN = 1'b1;
`else
    localparam bit MISAL_EN = 1'b0;
`endif

    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: outputs owed to writeback in order, and the
    // one memory op waiting for its bus response.
    exp_t        exp_q[$];
    bit          busy = 1'b0;
    op_t         cur;
    int unsigned cnt  = 0;

    task automatic check(input string tag, input u64 got, input u64 exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(msize_t s);
        return 1 << int'(s);
    endfunction

    function automatic int lane(u64 addr);
        return int'(addr % 64'd8);
    endfunction

    function automatic bit ref_mis(u64 addr, msize_t s);
        return (addr % u64'(nbytes(s))) != 64'd0;
    endfunction

    function automatic u8 ref_strobe(u64 addr, msize_t s);
        logic [15:0] m;
        m = (16'd1 << nbytes(s)) - 16'd1;
        m = m << lane(addr);
        return m[7:0];
    endfunction

    function automatic u64 ref_wdata(u64 addr, u64 rs2);
        return rs2 << (8 * lane(addr));
    endfunction

    function automatic u64 ref_load(u64 addr, msize_t s, bit uns, u64 rdata);
        u64 raw;
        u64 mask;
        int n;
        n   = nbytes(s);
        raw = rdata >> (8 * lane(addr));
        if (n == 8) return raw;
        mask = (64'd1 << (8 * n)) - 64'd1;
        raw  = raw & mask;
        if (!uns && raw[8*n-1]) raw = raw | ~mask;
        return raw;
    endfunction

    function automatic u64 c2u(ctl_t c);
        return {57'd0, c};
    endfunction

    function automatic op_t mk(u64 pc, bit rd, bit wr, bit uns, msize_t sz,
                               u64 rs2, u64 alu, u64 rdata, int unsigned dly);
        op_t o;
        o.e.pc              = pc;
        o.e.ctl             = '0;
        o.e.ctl.MemRead     = rd;
        o.e.ctl.MemWrite    = wr;
        o.e.ctl.MemUnsigned = uns;
        o.e.ctl.msize       = sz;
        o.e.ctl.RegWrite    = !wr;
        o.e.rs2             = rs2;
        o.e.alu             = alu;
        o.rdata             = rdata;
        o.delay             = dly;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        int  kind;
        kind                 = $urandom_range(0, 2);
        o.e.pc               = {$urandom, $urandom};
        o.e.rs2              = {$urandom, $urandom};
        o.e.alu              = {$urandom, $urandom};
        o.e.ctl              = '0;
        o.e.ctl.MemRead      = (kind == 1);
        o.e.ctl.MemWrite     = (kind == 2);
        o.e.ctl.MemUnsigned  = 1'($urandom_range(0, 1));
        o.e.ctl.msize        = msize_t'($urandom_range(0, 3));
        o.e.ctl.RegWrite     = 1'($urandom_range(0, 1));
        o.e.ctl.exc_misalign = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) != 0)
            o.e.alu = o.e.alu & ~u64'(nbytes(o.e.ctl.msize) - 1);
        o.rdata = {$urandom, $urandom};
        o.delay = $urandom_range(0, 4);
        return o;
    endfunction

    // One clock: drive at the falling edge, compare the settled outputs with
    // the model, then advance the model across the coming rising edge.
    task automatic step(input bit ve, input op_t op, input bit rw);
        bit   give_ok;
        bit   exp_rm;
        bit   exp_vm;
        bit   is_mem;
        bit   mis;
        exp_t x;
        @(negedge clk);
        validE  = ve;
        dataE   = op.e;
        readyW  = rw;
        dresp   = '0;
        give_ok = 1'b0;
        if (busy) begin
            dresp.data = cur.rdata;
            if (cnt == 0) begin
                give_ok       = 1'b1;
                dresp.data_ok = 1'b1;
            end else begin
                cnt--;
                dresp.addr_ok = 1'($urandom_range(0, 1));
            end
        end else begin
            dresp.data = {$urandom, $urandom};
        end
        #1;
        exp_vm = (exp_q.size() != 0) && !busy;
        exp_rm = !busy && ((exp_q.size() == 0) || rw);
        check("readyM", 64'(readyM), 64'(exp_rm));
        check("validM", 64'(validM), 64'(exp_vm));
        check("dreq.valid", 64'(dreq.valid), 64'(busy));
        if (busy) begin
            check("dreq.addr", dreq.addr, cur.e.alu);
            check("dreq.size", {62'd0, dreq.size}, {62'd0, cur.e.ctl.msize});
            check("dreq.strobe", {56'd0, dreq.strobe},
                  cur.e.ctl.MemWrite ? {56'd0, ref_strobe(cur.e.alu, cur.e.ctl.msize)} : 64'd0);
            if (cur.e.ctl.MemWrite)
                check("dreq.data", dreq.data, ref_wdata(cur.e.alu, cur.e.rs2));
        end
        if (exp_vm) begin
            check("dataM.pc", dataM.pc, exp_q[0].pc);
            check("dataM.ctl", c2u(dataM.ctl), c2u(exp_q[0].ctl));
            if (exp_q[0].chk_result)
                check("dataM.result", dataM.result, exp_q[0].result);
        end

        if (give_ok) begin
            busy = 1'b0;
            if (cur.e.ctl.MemRead) begin
                x            = exp_q[exp_q.size()-1];
                x.result     = ref_load(cur.e.alu, cur.e.ctl.msize, cur.e.ctl.MemUnsigned, cur.rdata);
                x.chk_result = 1'b1;
                exp_q[exp_q.size()-1] = x;
            end
        end
        if (exp_vm && rw) void'(exp_q.pop_front());
        if (ve && exp_rm) begin
            is_mem             = op.e.ctl.MemRead || op.e.ctl.MemWrite;
            mis                = MISAL_EN && is_mem && ref_mis(op.e.alu, op.e.ctl.msize);
            x.pc               = op.e.pc;
            x.ctl              = op.e.ctl;
            x.ctl.exc_misalign = mis;
            x.result           = op.e.alu;
            x.chk_result       = !is_mem || mis;
            exp_q.push_back(x);
            if (is_mem && !mis) begin
                busy = 1'b1;
                cur  = op;
                cnt  = op.delay;
            end
        end
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !busy) break;
            step(1'b0, rand_op(), 1'b1);
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        resetn = 1'b0;
        validE = 1'b0;
        dataE  = '0;
        readyW = 1'b0;
        dresp  = '0;

        repeat (2) @(negedge clk);
        #1;
        check("rst.readyM", 64'(readyM), 64'd1);
        check("rst.validM", 64'(validM), 64'd0);
        check("rst.dreq.valid", 64'(dreq.valid), 64'd0);
        check("rst.dataM.result", dataM.result, 64'd0);
        check("rst.dataM.pc", dataM.pc, 64'd0);
        check("rst.dataM.ctl", c2u(dataM.ctl), 64'd0);
        resetn = 1'b1;

        // Back-to-back ALU ops with writeback always ready.
        step(1'b1, mk(64'h100, 0, 0, 0, MSIZE8, 64'd0, 64'h1234, 64'd0, 0), 1'b1);
        step(1'b1, mk(64'h104, 0, 0, 0, MSIZE8, 64'd0, 64'h5678, 64'd0, 0), 1'b1);
        step(1'b1, mk(64'h108, 0, 0, 0, MSIZE8, 64'd0, 64'h9ABC, 64'd0, 0), 1'b1);
        drain(10);

        // Byte store at lane 3.
        step(1'b1, mk(64'h200, 0, 1, 0, MSIZE1, 64'hAB, 64'h1003, 64'd0, 3), 1'b1);
        drain(20);

        // Signed and unsigned byte load from lane 5.
        step(1'b1, mk(64'h300, 1, 0, 0, MSIZE1, 64'd0, 64'h2005, 64'h0000_8000_0000_0000, 1), 1'b1);
        drain(20);
        step(1'b1, mk(64'h304, 1, 0, 1, MSIZE1, 64'd0, 64'h2005, 64'h0000_8000_0000_0000, 1), 1'b1);
        drain(20);

        // Slow word load, then writeback stalls for three cycles.
        step(1'b1, mk(64'h400, 1, 0, 0, MSIZE4, 64'd0, 64'h3000, 64'h1122_3344_8899_AABB, 4), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, rand_op(), 1'b0);
        drain(20);

        // Misaligned word store crossing the top lane.
        step(1'b1, mk(64'h500, 0, 1, 0, MSIZE4, 64'hDEAD_BEEF, 64'h5006, 64'd0, 2), 1'b1);
        drain(20);

        // Reset asserted while the bus request is pending.
        step(1'b1, mk(64'h600, 1, 0, 0, MSIZE8, 64'd0, 64'h6000, 64'd0, 4), 1'b1);
        step(1'b0, rand_op(), 1'b1);
        @(negedge clk);
        resetn = 1'b0;
        validE = 1'b0;
        dresp  = '0;
        #1;
        check("midrst.dreq.valid", 64'(dreq.valid), 64'd0);
        check("midrst.validM", 64'(validM), 64'd0);
        check("midrst.readyM", 64'(readyM), 64'd1);
        busy = 1'b0;
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        step(1'b0, rand_op(), 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
        // Misaligned doubleword load traps without touching the bus.
        step(1'b1, mk(64'h700, 1, 0, 0, MSIZE8, 64'd0, 64'h4004, 64'd0, 0), 1'b0);
        step(1'b0, rand_op(), 1'b0);
        drain(10);
`endif

        for (int i = 0; i < 2000; i++)
            step(1'($urandom_range(0, 3) != 0), rand_op(), 1'($urandom_range(0, 3) != 0));
        drain(50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
